// File: rtl/down_timer_arbiter_pkg.sv
// Shared constants for the down-counter arbiter: FSM state encoding and default sizes.
package down_timer_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/down_cnt_ld.sv
// Loadable down counter with zero flag; load beats decrement.
module down_cnt_ld #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= q - 1'b1;
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/down_timer_arbiter.sv
// Round-robin owner selection for one shared down counter; the owner gets a done pulse
// when its countdown reaches zero, or is released silently if it withdraws its request.
module down_timer_arbiter
    import down_timer_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] load_val,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0]   RR_INIT = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE     = NREQ'(1);

    logic [1:0]       state;
    logic [IW-1:0]    rr_last;
    logic [IW-1:0]    win;
    logic             found;
    logic             any_req;
    logic             owner_req;
    int               idx;
    logic             cnt_load;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_d;
    logic             cnt_zero;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        win   = rr_last;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_last) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    assign any_req   = |req;
    assign owner_req = |(req & grant);

    // A cancel reloads zero so the counter reads 0 again once the block is idle.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_d    = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    cnt_load = 1'b1;
                    cnt_d    = load_val[int'(win)*WIDTH +: WIDTH];
                end
            end
            ST_COUNT: begin
                if (!owner_req) begin
                    cnt_load = 1'b1;
                end else if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    down_cnt_ld #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .d    (cnt_d),
        .q    (count),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
            rr_last <= RR_INIT;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state   <= ST_COUNT;
                        grant   <= ONE << win;
                        rr_last <= win;
                        busy    <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (!owner_req) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (cnt_zero) begin
                        state <= ST_DONE;
                        done  <= grant;
                        grant <= '0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer_arbiter.sv
// Directed bench: stimulus pushes expected per-cycle snapshots and done events into queues,
// an independent negedge monitor pops and compares them against the DUT outputs.
module tb_down_timer_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    typedef struct {
        int         cyc;
        logic [3:0] grant;
        logic [3:0] done;
        logic       busy;
        logic [3:0] count;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [3:0] done;
    } done_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] load_val;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;

    snap_t exp_q[$];
    done_t done_q[$];
    int    cyc     = 0;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    b;

    down_timer_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (load_val),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic set_load(input int i, input logic [3:0] v);
        load_val[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic expect_at(input int c, input logic [3:0] g, input logic [3:0] d,
                             input logic bz, input logic [3:0] cnt);
        snap_t s;
        s.cyc   = c;
        s.grant = g;
        s.done  = d;
        s.busy  = bz;
        s.count = cnt;
        exp_q.push_back(s);
    endtask

    task automatic expect_idle(input int c);
        expect_at(c, 4'b0000, 4'b0000, 1'b0, 4'd0);
    endtask

    // A full service: grant from g0 while counting l..0, done one cycle later, then idle.
    task automatic expect_service(input int g0, input int owner, input int l);
        logic [3:0] oh;
        done_t      de;
        oh = 4'b0001 << owner;
        for (int k = 0; k <= l; k++) expect_at(g0 + k, oh, 4'b0000, 1'b1, 4'(l - k));
        expect_at(g0 + l + 1, 4'b0000, oh, 1'b1, 4'd0);
        de.cyc  = g0 + l + 1;
        de.done = oh;
        done_q.push_back(de);
        expect_idle(g0 + l + 2);
    endtask

    task automatic checkOutput(input snap_t e);
        n_tests++;
        if (grant !== e.grant || done !== e.done || busy !== e.busy || count !== e.count) begin
            n_fail++;
            $display("[TB] FAIL snapshot@%0d: got grant=%b done=%b busy=%b count=%0d, want grant=%b done=%b busy=%b count=%0d",
                     cyc, grant, done, busy, count, e.grant, e.done, e.busy, e.count);
        end
    endtask

    always @(negedge clk) begin
        snap_t s;
        done_t de;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            s = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("[TB] FAIL snapshot_missed: expected cycle %0d, now at cycle %0d", s.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            s = exp_q.pop_front();
            checkOutput(s);
        end
        while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
            de = done_q.pop_front();
            n_tests++;
            n_fail++;
            $display("[TB] FAIL done_missing: got no pulse at cycle %0d, want done=%b", de.cyc, de.done);
        end
        if (done !== 4'b0000) begin
            n_tests++;
            if (done_q.size() == 0 || done_q[0].cyc != cyc) begin
                n_fail++;
                $display("[TB] FAIL done_unexpected: got done=%b at cycle %0d, want none", done, cyc);
            end else begin
                de = done_q.pop_front();
                if (done !== de.done) begin
                    n_fail++;
                    $display("[TB] FAIL done_value@%0d: got %b, want %b", cyc, done, de.done);
                end
            end
        end
    end

    initial begin
        repeat (3000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no completion after 3000 cycles, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held two edges with every requester asking; requester 0 wins first.
        rst      = 1'b0;
        req      = 4'b1111;
        load_val = '0;
        for (int i = 0; i < NREQ; i++) set_load(i, 4'd1);
        expect_idle(1);
        expect_idle(2);
        expect_service(3, 0, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(4'b0001);
        wait_until(5);
        applyStimulus(4'b0000);
        wait_until(6);

        // Single requester 0, load 3.
        b = cyc;
        set_load(0, 4'd3);
        applyStimulus(4'b0001);
        expect_service(b + 1, 0, 3);
        wait_until(b + 5);
        applyStimulus(4'b0000);
        wait_until(b + 6);

        // Full-range load 15 on requester 3; a later load_val change must be ignored.
        b = cyc;
        set_load(3, 4'd15);
        applyStimulus(4'b1000);
        expect_service(b + 1, 3, 15);
        wait_until(b + 3);
        set_load(3, 4'd7);
        wait_until(b + 17);
        applyStimulus(4'b0000);
        wait_until(b + 18);

        // All four requesting with load 0: round-robin 0,1,2,3, each owner leaving in DONE.
        b = cyc;
        for (int i = 0; i < NREQ; i++) set_load(i, 4'd0);
        applyStimulus(4'b1111);
        for (int i = 0; i < NREQ; i++) expect_service(b + 1 + 3 * i, i, 0);
        for (int i = 0; i < NREQ; i++) begin
            wait_until(b + 2 + 3 * i);
            req[i] = 1'b0;
        end
        wait_until(b + 12);

        // Cancel by requester 2 at count 5; requester 1 arriving mid-count is served after.
        b = cyc;
        set_load(2, 4'd9);
        set_load(1, 4'd2);
        applyStimulus(4'b0100);
        for (int k = 0; k < 5; k++) expect_at(b + 1 + k, 4'b0100, 4'b0000, 1'b1, 4'(9 - k));
        expect_idle(b + 6);
        expect_service(b + 7, 1, 2);
        wait_until(b + 5);
        applyStimulus(4'b0010);
        wait_until(b + 10);
        applyStimulus(4'b0000);
        wait_until(b + 11);

        // Reset mid-count, then rr pointer must be back at 3 so requester 1 beats 2.
        b = cyc;
        set_load(1, 4'd12);
        applyStimulus(4'b0010);
        for (int k = 0; k < 6; k++) expect_at(b + 1 + k, 4'b0010, 4'b0000, 1'b1, 4'(12 - k));
        expect_idle(b + 7);
        expect_service(b + 8, 1, 1);
        wait_until(b + 6);
        rst = 1'b0;
        wait_until(b + 7);
        rst = 1'b1;
        set_load(1, 4'd1);
        set_load(2, 4'd5);
        applyStimulus(4'b0110);
        wait_until(b + 8);
        applyStimulus(4'b0010);
        wait_until(b + 10);
        applyStimulus(4'b0000);
        wait_until(b + 14);

        if (exp_q.size() != 0 || done_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL leftover_expectations: got %0d snapshots and %0d done events unchecked, want 0",
                     exp_q.size(), done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
